// File: rtl/pixel_write_sched_if.sv
// Graphics-side bundle for the VRAM write scheduler: clear/pixel requests
// from the CPU graphics unit plus the MIG user write and command FIFO signals.
interface pixel_write_sched_if;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        clear_screen_done;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_x;
  logic [7:0]  px_y;
  logic [7:0]  px_color;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_wr_data;
  logic        mem_wr_full;
  logic        mem_wr_empty;
  logic        mem_wr_underrun;
  logic        mem_wr_error;
  logic        mem_error;

  modport slave (
    input  clear_req, clear_color, px_valid, px_x, px_y, px_color,
           mem_cmd_full, mem_wr_full, mem_wr_empty, mem_wr_underrun, mem_wr_error,
    output clear_busy, clear_screen_done, px_ready,
           mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
           mem_wr_en, mem_wr_mask, mem_wr_data, mem_error
  );

  modport master (
    output clear_req, clear_color, px_valid, px_x, px_y, px_color,
           mem_cmd_full, mem_wr_full, mem_wr_empty, mem_wr_underrun, mem_wr_error,
    input  clear_busy, clear_screen_done, px_ready,
           mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
           mem_wr_en, mem_wr_mask, mem_wr_data, mem_error
  );
endinterface

// File: rtl/pixel_write_sched.sv
// VRAM write-port scheduler: full-screen fills (boot and requested) and
// single-pixel CPU writes, serialised onto one MIG write/command port pair.
module pixel_write_sched #(
  parameter logic [13:0] PREFIX     = 14'h0C00,
  parameter int          LINES      = 192,
  parameter int          LINE_WORDS = 64
) (
  input  logic               clk,
  input  logic               rst,
  pixel_write_sched_if.slave bus
);
  localparam int            CW        = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);
  localparam logic [7:0]    LAST_LINE = 8'(LINES - 1);
  localparam logic [5:0]    FILL_BL   = 6'(LINE_WORDS - 1);
  localparam logic [29:0]   BASE_ADDR = {PREFIX, 16'h0000};

  typedef enum logic [2:0] {IDLE, FILL, FCMD, FDRAIN, PDATA, PCMD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    line_q, line_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    fcol_q, fcol_d;
  logic          pend_q, pend_d;
  logic [7:0]    pcol_q, pcol_d;
  logic [7:0]    pxx_q, pxx_d;
  logic [7:0]    pxy_q, pxy_d;
  logic [7:0]    pxc_q, pxc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          wr_en, cmd_en, px_ready, busy;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;
  logic [5:0]    cmd_bl;
  logic [29:0]   cmd_addr;

  function automatic logic [3:0] byte_mask(input logic [1:0] lane);
    byte_mask = ~(4'b0001 << lane);
  endfunction

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    fcol_d   = fcol_q;
    pend_d   = pend_q;
    pcol_d   = pcol_q;
    pxx_d    = pxx_q;
    pxy_d    = pxy_q;
    pxc_d    = pxc_q;
    done_d   = done_q;
    err_d    = err_q | bus.mem_wr_underrun | bus.mem_wr_error;
    wr_en    = 1'b0;
    cmd_en   = 1'b0;
    px_ready = 1'b0;
    busy     = 1'b0;
    wr_mask  = 4'hF;
    wr_data  = 32'h0;
    cmd_bl   = 6'h0;
    cmd_addr = BASE_ADDR;

    // One-deep pending clear; later requests merge and the latest colour wins.
    if (bus.clear_req) begin
      pend_d = 1'b1;
      pcol_d = bus.clear_color;
    end

    case (state_q)
      IDLE: begin
        if (pend_q || bus.clear_req) begin
          fcol_d  = bus.clear_req ? bus.clear_color : pcol_q;
          pend_d  = 1'b0;
          line_d  = 8'h00;
          cnt_d   = '0;
          state_d = FILL;
        end else begin
          px_ready = 1'b1;
          if (bus.px_valid && (bus.px_y <= LAST_LINE)) begin
            pxx_d   = bus.px_x;
            pxy_d   = bus.px_y;
            pxc_d   = bus.px_color;
            state_d = PDATA;
          end
        end
      end
      FILL: begin
        busy    = 1'b1;
        wr_mask = 4'h0;
        wr_data = {4{fcol_q}};
        if (!bus.mem_wr_full) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = FCMD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FCMD: begin
        busy     = 1'b1;
        cmd_bl   = FILL_BL;
        cmd_addr = {PREFIX, line_q, 8'h00};
        if (!bus.mem_cmd_full) begin
          cmd_en  = 1'b1;
          state_d = FDRAIN;
        end
      end
      FDRAIN: begin
        busy = 1'b1;
        if (bus.mem_wr_empty) begin
          if (line_q == LAST_LINE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            line_d  = line_q + 8'd1;
            state_d = FILL;
          end
        end
      end
      PDATA: begin
        wr_mask = byte_mask(pxx_q[1:0]);
        wr_data = {4{pxc_q}};
        if (!bus.mem_wr_full) begin
          wr_en   = 1'b1;
          state_d = PCMD;
        end
      end
      PCMD: begin
        cmd_addr = {PREFIX, pxy_q, pxx_q[7:2], 2'b00};
        if (!bus.mem_cmd_full) begin
          cmd_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = FILL;
    endcase

    // While rst is high the port must look idle even before the state resets.
    if (rst) begin
      wr_en    = 1'b0;
      cmd_en   = 1'b0;
      px_ready = 1'b0;
      busy     = 1'b0;
      wr_mask  = 4'hF;
      wr_data  = 32'h0;
      cmd_bl   = 6'h0;
      cmd_addr = BASE_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      line_q  <= 8'h00;
      cnt_q   <= '0;
      fcol_q  <= 8'h00;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      fcol_q  <= fcol_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    pcol_q <= pcol_d;
    pxx_q  <= pxx_d;
    pxy_q  <= pxy_d;
    pxc_q  <= pxc_d;
  end

  assign bus.mem_wr_en         = wr_en;
  assign bus.mem_wr_mask       = wr_mask;
  assign bus.mem_wr_data       = wr_data;
  assign bus.mem_cmd_en        = cmd_en;
  assign bus.mem_cmd_instr     = 3'b000;
  assign bus.mem_cmd_bl        = cmd_bl;
  assign bus.mem_cmd_byte_addr = cmd_addr;
  assign bus.px_ready          = px_ready;
  assign bus.clear_busy        = busy;
  assign bus.clear_screen_done = done_q & ~rst;
  assign bus.mem_error         = err_q & ~rst;
endmodule

// File: tb/tb_pixel_write_sched.sv
// Bench for pixel_write_sched: queue-based expected write/command stream,
// a small MIG FIFO model, directed boundary cases and randomized pixels.
module tb_pixel_write_sched;
  localparam logic [13:0] PREFIX = 14'h0C00;
  localparam int          LINES  = 192;
  localparam int          LW     = 64;

  logic clk = 1'b0;
  logic rst;
  pixel_write_sched_if bus();

  pixel_write_sched #(.PREFIX(PREFIX), .LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [35:0] exp_w[$];  // {mask, data}
  logic [35:0] exp_c[$];  // {bl, byte_addr}

  logic stall_en = 1'b0, force_wf = 1'b0, force_cf = 1'b0;
  logic rnd_wf = 1'b0, rnd_cf = 1'b0;
  logic fifo_empty = 1'b1;
  int   fcount = 0, owed = 0, wr_since = 0, n_cmd = 0, pop = 0;
  logic [35:0] m_e;

  assign bus.mem_wr_full  = force_wf | rnd_wf;
  assign bus.mem_cmd_full = force_cf | rnd_cf;
  assign bus.mem_wr_empty = fifo_empty;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic exp_fill(input logic [7:0] c);
    for (int l = 0; l < LINES; l++) begin
      for (int w = 0; w < LW; w++) exp_w.push_back({4'h0, c, c, c, c});
      exp_c.push_back({6'(LW - 1), {PREFIX, 16'h0} + 30'(l * 256)});
    end
  endtask

  task automatic exp_pixel(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    logic [3:0] m;
    if (int'(y) < LINES) begin
      m = 4'hF;
      m[x[1:0]] = 1'b0;
      exp_w.push_back({m, c, c, c, c});
      exp_c.push_back({6'd0, {PREFIX, 16'h0} + 30'(int'(y) * 256 + (int'(x) / 4) * 4)});
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wr_en"},  64'(bus.mem_wr_en), 64'd0);
    chk({tag, "_cmd_en"}, 64'(bus.mem_cmd_en), 64'd0);
    chk({tag, "_mask"},   64'(bus.mem_wr_mask), 64'hF);
    chk({tag, "_data"},   64'(bus.mem_wr_data), 64'd0);
    chk({tag, "_addr"},   64'(bus.mem_cmd_byte_addr), 64'({PREFIX, 16'h0}));
    chk({tag, "_bl"},     64'(bus.mem_cmd_bl), 64'd0);
    chk({tag, "_instr"},  64'(bus.mem_cmd_instr), 64'd0);
    chk({tag, "_busy"},   64'(bus.clear_busy), 64'd0);
    chk({tag, "_done"},   64'(bus.clear_screen_done), 64'd0);
    chk({tag, "_ready"},  64'(bus.px_ready), 64'd0);
    chk({tag, "_err"},    64'(bus.mem_error), 64'd0);
  endtask

  task automatic wait_fill(input string tag);
    int n = 0;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(bus.clear_busy), 64'd1);
    while (bus.clear_busy && n < 20000) begin
      chk({tag, "_rdy_low"}, 64'(bus.px_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_finish"}, 64'(n < 20000), 64'd1);
    chk({tag, "_done"},   64'(bus.clear_screen_done), 64'd1);
    chk({tag, "_wq"},     64'(exp_w.size()), 64'd0);
    chk({tag, "_cq"},     64'(exp_c.size()), 64'd0);
  endtask

  // Call just after an active edge; returns just after the accepting edge.
  task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    int n = 0;
    bus.px_x = x;
    bus.px_y = y;
    bus.px_color = c;
    bus.px_valid = 1'b1;
    exp_pixel(x, y, c);
    @(negedge clk);
    while (!bus.px_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("px_accept", 64'(n < 1000), 64'd1);
    @(posedge clk);
    #1 bus.px_valid = 1'b0;
  endtask

  // MIG side: check every push against the expected stream and drain the FIFO.
  always @(negedge clk) begin
    if (rst) begin
      fcount = 0; owed = 0; wr_since = 0;
    end else begin
      if (bus.mem_wr_en) begin
        chk("wr_while_full", 64'(bus.mem_wr_full), 64'd0);
        chk("wr_expected", 64'(exp_w.size() != 0), 64'd1);
        if (exp_w.size() != 0) begin
          m_e = exp_w.pop_front();
          chk("wr_data", 64'(bus.mem_wr_data), 64'(m_e[31:0]));
          chk("wr_mask", 64'(bus.mem_wr_mask), 64'(m_e[35:32]));
        end
        fcount++;
        wr_since++;
      end
      if (bus.mem_cmd_en) begin
        chk("cmd_while_full", 64'(bus.mem_cmd_full), 64'd0);
        chk("cmd_instr", 64'(bus.mem_cmd_instr), 64'd0);
        chk("cmd_expected", 64'(exp_c.size() != 0), 64'd1);
        if (exp_c.size() != 0) begin
          m_e = exp_c.pop_front();
          chk("cmd_bl", 64'(bus.mem_cmd_bl), 64'(m_e[35:30]));
          chk("cmd_addr", 64'(bus.mem_cmd_byte_addr), 64'(m_e[29:0]));
        end
        chk("cmd_words_before", 64'(wr_since), 64'(int'(bus.mem_cmd_bl) + 1));
        wr_since = 0;
        owed += int'(bus.mem_cmd_bl) + 1;
        n_cmd++;
      end
      pop = owed;
      if (pop > 8) pop = 8;
      if (pop > fcount) pop = fcount;
      owed -= pop;
      fcount -= pop;
    end
    fifo_empty = (fcount == 0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_wf = stall_en && ($urandom_range(0, 3) == 0);
    rnd_cf = stall_en && ($urandom_range(0, 3) == 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int start;
    logic [7:0] rx, ry, rc;
    bus.clear_req = 1'b0;  bus.clear_color = 8'h00;
    bus.px_valid = 1'b0;   bus.px_x = 8'h00; bus.px_y = 8'h00; bus.px_color = 8'h00;
    bus.mem_wr_underrun = 1'b0; bus.mem_wr_error = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    exp_fill(8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Boot fill, no stalls
    wait_fill("boot");
    chk("boot_idle_ready", 64'(bus.px_ready), 64'd1);

    // Directed pixel x=5 y=3
    @(posedge clk); #1;
    send_px(8'd5, 8'd3, 8'hA7);
    @(negedge clk);
    chk("p2_wr_en", 64'(bus.mem_wr_en), 64'd1);
    chk("p2_data",  64'(bus.mem_wr_data), 64'hA7A7A7A7);
    chk("p2_mask",  64'(bus.mem_wr_mask), 64'b1101);
    @(negedge clk);
    chk("p2_cmd_en", 64'(bus.mem_cmd_en), 64'd1);
    chk("p2_addr",   64'(bus.mem_cmd_byte_addr), 64'({PREFIX, 16'h0304}));
    chk("p2_bl",     64'(bus.mem_cmd_bl), 64'd0);

    // Write-FIFO full for 10 cycles in the middle of a requested fill
    @(posedge clk); #1;
    bus.clear_req = 1'b1; bus.clear_color = 8'h55;
    exp_fill(8'h55);
    @(posedge clk); #1 bus.clear_req = 1'b0;
    repeat (20) @(posedge clk);
    #1 force_wf = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t3_no_push_full", 64'(bus.mem_wr_en), 64'd0);
    end
    @(posedge clk); #1 force_wf = 1'b0;
    wait_fill("fill55");

    // Command FIFO full while a pixel sits in PCMD
    @(posedge clk); #1 force_cf = 1'b1;
    send_px(8'd9, 8'd10, 8'h3C);
    repeat (6) begin
      @(negedge clk);
      chk("t3_cmd_held", 64'(bus.mem_cmd_en), 64'd0);
    end
    chk("t3_ready_in_pcmd", 64'(bus.px_ready), 64'd0);
    @(posedge clk); #1 force_cf = 1'b0;
    @(negedge clk);
    chk("t3_cmd_release", 64'(bus.mem_cmd_en), 64'd1);

    // Same-cycle clear request and pixel: the fill wins
    @(posedge clk); #1;
    bus.clear_req = 1'b1; bus.clear_color = 8'h1F;
    bus.px_x = 8'd20; bus.px_y = 8'd30; bus.px_color = 8'h99; bus.px_valid = 1'b1;
    exp_fill(8'h1F);
    exp_pixel(8'd20, 8'd30, 8'h99);
    @(negedge clk);
    chk("t4_ready_vs_clear", 64'(bus.px_ready), 64'd0);
    @(posedge clk); #1 bus.clear_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.px_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_accept", 64'(n < 20000), 64'd1);
    chk("t4_busy_at_accept", 64'(bus.clear_busy), 64'd0);
    chk("t4_fill_cmds_done", 64'(exp_c.size()), 64'd1);
    @(posedge clk); #1 bus.px_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_wq", 64'(exp_w.size()), 64'd0);
    chk("t4_cq", 64'(exp_c.size()), 64'd0);

    // Off-screen pixel: handshake only
    @(posedge clk); #1;
    send_px(8'd7, 8'd200, 8'h11);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_wr",  64'(bus.mem_wr_en), 64'd0);
      chk("t5_no_cmd", 64'(bus.mem_cmd_en), 64'd0);
    end
    chk("t5_ready_back", 64'(bus.px_ready), 64'd1);

    // Sticky error flag
    chk("t5_err_before", 64'(bus.mem_error), 64'd0);
    @(posedge clk); #1 bus.mem_wr_error = 1'b1;
    @(posedge clk); #1 bus.mem_wr_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", 64'(bus.mem_error), 64'd1);

    // Randomized pixels under random FIFO backpressure
    @(posedge clk); #1 stall_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom_range(0, 223));
      rc = 8'($urandom);
      send_px(rx, ry, rc);
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk); #1;
      end
    end
    stall_en = 1'b0;
    n = 0;
    while ((exp_w.size() != 0 || exp_c.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rnd_wq", 64'(exp_w.size()), 64'd0);
    chk("rnd_cq", 64'(exp_c.size()), 64'd0);
    chk("rnd_err_still", 64'(bus.mem_error), 64'd1);

    // Reset during line 50 of a requested fill
    @(posedge clk); #1;
    bus.clear_req = 1'b1; bus.clear_color = 8'h3C;
    exp_fill(8'h3C);
    start = n_cmd;
    @(posedge clk); #1 bus.clear_req = 1'b0;
    n = 0;
    while ((n_cmd - start) < 50 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_line50", 64'(n < 10000), 64'd1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_w.delete();
    exp_c.delete();
    exp_fill(8'h00);
    @(negedge clk);
    check_reset("t6_rst_a");
    @(posedge clk); #1;
    @(negedge clk);
    check_reset("t6_rst_b");
    @(posedge clk); #1 rst = 1'b0;
    wait_fill("reboot");
    chk("t6_err_cleared", 64'(bus.mem_error), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
